outport_tx: RTL and testbench



---
 rtl/outport_tx.sv | 101 ++++++++++
 tb/tb_outport_tx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/outport_tx.sv
// Output-port transmitter: buffers words captured from the datapath bus and
// hands them one at a time to an external device over a valid/ack handshake.
module outport_tx #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [DATA_W-1:0] bus_contents,
   input  logic              OutPort_enable,
   input  logic              out_ack,
   output logic [DATA_W-1:0] outport_data_out,
   output logic              out_valid,
   output logic              out_full,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic {IDLE, SEND} state_t;

   state_t            state;
   state_t            next_state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              pop;
   logic              push;
   logic              drop;

   assign out_full  = (count == FULL_CNT);
   assign out_count = count;
   assign out_valid = (state == SEND);

   // Pop loads the presentation register whenever it is empty or being acked;
   // a push at full is still legal when a pop frees a slot on the same edge.
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      unique case (state)
         IDLE: begin
            if (count != '0) begin
               pop        = 1'b1;
               next_state = SEND;
            end
         end
         SEND: begin
            if (out_ack) begin
               if (count != '0) begin
                  pop = 1'b1;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
      push = OutPort_enable && (!out_full || pop);
      drop = OutPort_enable && out_full && !pop;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state            <= IDLE;
         outport_data_out <= '0;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         count            <= '0;
         out_overflow     <= 1'b0;
      end else begin
         state <= next_state;
         if (pop) begin
            outport_data_out <= mem[rd_ptr];
            rd_ptr           <= rd_ptr + 1'b1;
         end
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop) begin
            out_overflow <= 1'b1;
         end
      end
   end

   // Storage array carries no reset; the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (!clr && push) begin
         mem[wr_ptr] <= bus_contents;
      end
   end

endmodule

// File: tb/tb_outport_tx.sv
// Self-checking bench for outport_tx: queue-based reference model of the
// buffer plus presentation slot, and a scoreboard of words the device must see.
module tb_outport_tx;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic              clk;
   logic              clr;
   logic [DATA_W-1:0] bus_contents;
   logic              OutPort_enable;
   logic              out_ack;
   logic [DATA_W-1:0] outport_data_out;
   logic              out_valid;
   logic              out_full;
   logic [CNT_W-1:0]  out_count;
   logic              out_overflow;

   int checks = 0;
   int errors = 0;

   logic [31:0] mFifo[$];
   logic [31:0] expQ[$];
   bit          mHas;
   logic [31:0] mData;
   bit          mOvf;
   bit          monitorOn = 1'b0;

   outport_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk              (clk),
      .clr              (clr),
      .bus_contents     (bus_contents),
      .OutPort_enable   (OutPort_enable),
      .out_ack          (out_ack),
      .outport_data_out (outport_data_out),
      .out_valid        (out_valid),
      .out_full         (out_full),
      .out_count        (out_count),
      .out_overflow     (out_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic c, input logic en,
                                input logic [31:0] d, input logic a);
      clr            = c;
      OutPort_enable = en;
      bus_contents   = d;
      out_ack        = a;
      @(posedge clk);
      #1;
   endtask

   // Reference model: one FIFO queue plus a single presentation slot.
   always @(posedge clk) begin
      bit          doPop;
      bit          doPush;
      logic [31:0] head;
      if (clr) begin
         mFifo.delete();
         expQ.delete();
         mHas  = 1'b0;
         mData = '0;
         mOvf  = 1'b0;
      end else begin
         doPop  = (mFifo.size() > 0) && (!mHas || out_ack);
         doPush = OutPort_enable && ((mFifo.size() < DEPTH) || doPop);
         if (OutPort_enable && !doPush) mOvf = 1'b1;
         head = '0;
         if (doPop) head = mFifo.pop_front();
         if (doPush) begin
            mFifo.push_back(bus_contents);
            expQ.push_back(bus_contents);
         end
         if (doPop) begin
            mData = head;
            mHas  = 1'b1;
         end else if (mHas && out_ack) begin
            mHas = 1'b0;
         end
      end
   end

   // Monitor: status against the model, transferred words against the scoreboard.
   always @(negedge clk) begin
      if (monitorOn) begin
         checkOutput("out_valid", 32'(out_valid), 32'(mHas));
         checkOutput("out_count", 32'(out_count), 32'(mFifo.size()));
         checkOutput("out_full", 32'(out_full), 32'(mFifo.size() == DEPTH));
         checkOutput("out_overflow", 32'(out_overflow), 32'(mOvf));
         checkOutput("data_hold", outport_data_out, mData);
         if (out_valid && out_ack && !clr) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL xfer: got 0x%0h, expected no transfer", outport_data_out);
            end else begin
               checkOutput("xfer", outport_data_out, expQ.pop_front());
            end
         end
      end
   end

   initial begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      monitorOn = 1'b1;
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput("rst_valid", 32'(out_valid), 32'h0);
      checkOutput("rst_data", outport_data_out, 32'h0);
      checkOutput("rst_count", 32'(out_count), 32'h0);
      checkOutput("rst_full", 32'(out_full), 32'h0);
      checkOutput("rst_ovf", 32'(out_overflow), 32'h0);

      // Single word: latency, hold without ack, release on ack
      applyStimulus(1'b0, 1'b1, 32'h0000_00A5, 1'b0);
      checkOutput("a5_not_yet_valid", 32'(out_valid), 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("a5_valid", 32'(out_valid), 32'h1);
      checkOutput("a5_data", outport_data_out, 32'hA5);
      checkOutput("a5_count", 32'(out_count), 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("a5_held", 32'(out_valid), 32'h1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("a5_released", 32'(out_valid), 32'h0);
      checkOutput("a5_data_kept", outport_data_out, 32'hA5);

      // Back-to-back drain
      applyStimulus(1'b0, 1'b1, 32'h11, 1'b1);
      applyStimulus(1'b0, 1'b1, 32'h22, 1'b1);
      applyStimulus(1'b0, 1'b1, 32'h33, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("b2b_idle", 32'(out_valid), 32'h0);
      checkOutput("b2b_count", 32'(out_count), 32'h0);

      // Full and overflow
      for (int i = 1; i <= 6; i++) applyStimulus(1'b0, 1'b1, 32'(i), 1'b0);
      checkOutput("ovf_full", 32'(out_full), 32'h1);
      checkOutput("ovf_count", 32'(out_count), 32'h4);
      checkOutput("ovf_flag", 32'(out_overflow), 32'h1);
      checkOutput("ovf_present", outport_data_out, 32'h1);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("ovf_sticky", 32'(out_overflow), 32'h1);
      checkOutput("ovf_drained", 32'(out_valid), 32'h0);

      // Simultaneous push and pop at full
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      for (int i = 1; i <= 5; i++) applyStimulus(1'b0, 1'b1, 32'(i), 1'b0);
      checkOutput("pp_full_before", 32'(out_full), 32'h1);
      applyStimulus(1'b0, 1'b1, 32'h9, 1'b1);
      checkOutput("pp_data", outport_data_out, 32'h2);
      checkOutput("pp_count", 32'(out_count), 32'h4);
      checkOutput("pp_no_ovf", 32'(out_overflow), 32'h0);
      for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("pp_last", outport_data_out, 32'h9);

      // Pointer wrap
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 32'h100 + 32'(i), 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("wrap_last", outport_data_out, 32'h109);

      // Reset mid-operation
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 32'h200 + 32'(i), 1'b0);
      checkOutput("mid_valid", 32'(out_valid), 32'h1);
      checkOutput("mid_count", 32'(out_count), 32'h3);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      checkOutput("mid_rst_valid", 32'(out_valid), 32'h0);
      checkOutput("mid_rst_data", outport_data_out, 32'h0);
      checkOutput("mid_rst_count", 32'(out_count), 32'h0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("mid_quiet", 32'(out_valid), 32'h0);

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1),
                       $urandom, ($urandom_range(0, 9) < 6));
      end
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("final_empty", 32'(expQ.size()), 32'h0);
      checkOutput("final_idle", 32'(out_valid), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
